// File: rtl/counter_two_speed.sv
// rtl/counter_two_speed.sv - two-digit BCD up/down counter with two-rate prescaler
// Optional macro COUNTER_TWO_SPEED_SYNC_INPUTS_EN adds 2-flop synchronizers on sel, SS and MODE.
module counter_two_speed #(
  parameter int         FAST_DIV  = 5000000,
  parameter int         SLOW_DIV  = 50000000,
  parameter logic [7:0] MAX_COUNT = 8'h59
) (
  input  logic       clk50m,
  input  logic       reset,
  input  logic       sel,
  input  logic       SS,
  input  logic       MODE,
  output logic [7:0] out
);

  localparam logic [25:0] FAST_LAST = 26'(FAST_DIV - 1);
  localparam logic [25:0] SLOW_LAST = 26'(SLOW_DIV - 1);

  logic sel_u;
  logic ss_u;
  logic mode_u;

`ifdef COUNTER_TWO_SPEED_SYNC_INPUTS_EN
  logic [1:0] sel_sync;
  logic [1:0] ss_sync;
  logic [1:0] mode_sync;

  always_ff @(posedge clk50m or negedge reset) begin
    if (!reset) begin
      sel_sync  <= 2'b00;
      ss_sync   <= 2'b00;
      mode_sync <= 2'b00;
    end else begin
      sel_sync  <= {sel_sync[0], sel};
      ss_sync   <= {ss_sync[0], SS};
      mode_sync <= {mode_sync[0], MODE};
    end
  end

  assign sel_u  = sel_sync[1];
  assign ss_u   = ss_sync[1];
  assign mode_u = mode_sync[1];
`else
  assign sel_u  = sel;
  assign ss_u   = SS;
  assign mode_u = MODE;
`endif

  logic        prev_sel;
  logic [25:0] prescaler;
  logic [25:0] div_last;
  logic        sel_chg;
  logic        tick;
  logic [7:0]  next_out;
  logic [3:0]  ones;
  logic [3:0]  tens;

  // A speed change restarts the prescaler and suppresses the tick on that edge.
  always_comb begin
    div_last = sel_u ? FAST_LAST : SLOW_LAST;
    sel_chg  = (sel_u != prev_sel);
    tick     = ss_u && !sel_chg && (prescaler == div_last);
  end

  always_comb begin
    ones     = out[3:0];
    tens     = out[7:4];
    next_out = out;
    if (out > MAX_COUNT) begin
      next_out = 8'h00;
    end else if (!mode_u) begin
      if (out == MAX_COUNT)  next_out = 8'h00;
      else if (ones == 4'd9) next_out = {tens + 4'd1, 4'd0};
      else                   next_out = {tens, ones + 4'd1};
    end else begin
      if (out == 8'h00)      next_out = MAX_COUNT;
      else if (ones == 4'd0) next_out = {tens - 4'd1, 4'd9};
      else                   next_out = {tens, ones - 4'd1};
    end
  end

  always_ff @(posedge clk50m or negedge reset) begin
    if (!reset) begin
      out       <= 8'h00;
      prescaler <= 26'd0;
      prev_sel  <= sel_u;
    end else begin
      prev_sel <= sel_u;
      if (sel_chg) begin
        prescaler <= 26'd0;
      end else if (ss_u) begin
        if (prescaler == div_last) prescaler <= 26'd0;
        else                       prescaler <= prescaler + 26'd1;
      end
      if (tick) out <= next_out;
    end
  end

endmodule

// File: tb/tb_counter_two_speed.sv
// tb/tb_counter_two_speed.sv - directed self-checking bench for counter_two_speed
module tb_counter_two_speed;

  logic       clk50m = 1'b0;
  logic       reset  = 1'b0;
  logic       sel    = 1'b1;
  logic       SS     = 1'b1;
  logic       MODE   = 1'b0;
  logic [7:0] out;

  int errors = 0;
  int checks = 0;

  counter_two_speed #(
    .FAST_DIV (4),
    .SLOW_DIV (10),
    .MAX_COUNT(8'h59)
  ) dut (
    .clk50m(clk50m),
    .reset (reset),
    .sel   (sel),
    .SS    (SS),
    .MODE  (MODE),
    .out   (out)
  );

  always #5 clk50m = ~clk50m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk50m);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) + (n % 10));
  endfunction

  initial begin
    // Reset, fast count up
    step(2);
    check("reset_out", out, 8'h00);
    reset = 1'b1;
    step(3);
    check("edge3_no_tick", out, 8'h00);
    step(1);
    check("edge4_first_tick", out, 8'h01);
    step(4);
    check("edge8_second_tick", out, 8'h02);
    step(28);
    check("edge36_09", out, 8'h09);
    step(4);
    check("edge40_10", out, 8'h10);

    // Count up to the wrap limit, checking every tick
    for (int t = 11; t <= 59; t++) begin
      step(4);
      check("up_tick", out, bcd(t));
    end
    step(4);
    check("wrap_up_59_to_00", out, 8'h00);

    MODE = 1'b1;
    step(4);
    check("wrap_down_00_to_59", out, 8'h59);
    step(4);
    check("down_58", out, 8'h58);
    for (int t = 57; t >= 9; t--) begin
      step(4);
      check("down_tick", out, bcd(t));
    end

    // Start/stop with prescaler at 2
    step(2);
    check("pre_hold", out, 8'h09);
    SS = 1'b0;
    step(50);
    check("hold_mid", out, 8'h09);
    step(50);
    check("hold_end", out, 8'h09);
    SS = 1'b1;
    step(1);
    check("resume_no_tick", out, 8'h09);
    step(1);
    check("resume_tick", out, 8'h08);

    // Count up to 37 then reset asynchronously between edges
    MODE = 1'b0;
    step(116);
    check("reach_37", out, 8'h37);
    #2;
    reset = 1'b0;
    sel   = 1'b0;
    #1;
    check("async_reset_immediate", out, 8'h00);
    step(2);
    check("reset_hold", out, 8'h00);
    reset = 1'b1;

    // Slow rate from reset, then speed switch with prescaler at 7
    step(9);
    check("slow_edge9", out, 8'h00);
    step(1);
    check("slow_edge10_tick", out, 8'h01);
    step(7);
    sel = 1'b1;
    step(1);
    check("sel_toggle_no_tick", out, 8'h01);
    step(3);
    check("after_toggle_3", out, 8'h01);
    step(1);
    check("after_toggle_4_tick", out, 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_two_speed.md
Name: counter_two_speed

Overview:
- Two-digit BCD up/down counter for the clock project, clocked from the 50 MHz board clock.
- An internal prescaler generates count-enable ticks at one of two rates, chosen by `sel`.
- `SS` starts and stops counting; `MODE` selects the count direction.
- The 8-bit BCD value drives the display/segment logic downstream.

Parameters:
- FAST_DIV, 5000000, clk50m cycles per tick when sel=1 (10 Hz at 50 MHz); legal range 1 to 2^26.
- SLOW_DIV, 50000000, clk50m cycles per tick when sel=0 (1 Hz); legal range 1 to 2^26.
- MAX_COUNT, 8'h59, BCD wrap limit. Must be valid BCD, 8'h01 to 8'h99.

Ports:
- clk50m  in  1  system clock, 50 MHz; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- sel  in  1  speed select: 1 = fast (FAST_DIV), 0 = slow (SLOW_DIV).
- SS  in  1  start/stop: 1 = run, 0 = hold.
- MODE  in  1  direction: 0 = count up, 1 = count down.
- out  out  8  BCD count. [7:4] = tens digit, [3:0] = ones digit.

Behaviour:
- Reset (reset=0, asynchronous):
  - out = 8'h00.
  - Prescaler = 0.
  - Stored previous-sel register = current sel.
  - Holds as long as reset=0.
- Prescaler:
  - 26-bit counter; DIV = FAST_DIV if sel=1, else SLOW_DIV.
  - On each edge with SS=1: if prescaler == DIV-1, then prescaler <= 0 and a tick fires on that same edge; otherwise prescaler increments.
  - SS=0: prescaler and out both hold their values; no tick fires.
  - First tick occurs on the DIV-th rising edge with SS=1 after reset releases.
  - Latency from tick to out update is 0: out changes on the tick edge itself.
- Speed change:
  - On any edge where sel differs from its registered previous value, prescaler <= 0 and no tick fires on that edge.
  - The next tick follows DIV(new) edges later.
  - The registered previous value updates on every edge.
- Tick, MODE=0 (up):
  - out == MAX_COUNT -> 8'h00.
  - Ones digit == 9 -> ones = 0, tens increments.
  - Otherwise ones increments.
- Tick, MODE=1 (down):
  - out == 8'h00 -> MAX_COUNT.
  - Ones digit == 0 -> ones = 9, tens decrements.
  - Otherwise ones decrements.
- MODE change takes effect on the next tick. The prescaler is not cleared by a MODE change.
- out is always valid BCD and never exceeds MAX_COUNT. If an out value greater than MAX_COUNT ever arises, the next tick loads 8'h00 in either direction.
- DIV=1: a tick fires every edge while SS=1 (except edges with a sel change).
- sel, SS and MODE are used directly as synchronous inputs (no synchronizers), unless the optional feature below is enabled.
- out is driven straight from a register; no combinational path from inputs to out.

Optional Feature:
- Macro: COUNTER_TWO_SPEED_SYNC_INPUTS_EN.
- Defined:
  - sel, SS and MODE each pass through a 2-flop synchronizer (flops reset to 0) before use.
  - Every input change takes effect 2 edges later than without the feature.
  - The sel-change detector operates on the synchronized sel.
- Undefined:
  - Inputs are used directly, as specified above.
  - No synchronizer flops are present.

Test Plan:
- Use FAST_DIV=4, SLOW_DIV=10, MAX_COUNT=8'h59 unless a scenario states otherwise.
- Reset and fast count up:
  - Stimulus: reset=0 for 2 cycles, then reset=1 with sel=1, SS=1, MODE=0.
  - Required: out=8'h00 during reset; out=8'h01 on the 4th edge after release, 8'h02 on the 8th; out=8'h10 after 40 edges.
- Wrap both directions:
  - Stimulus: count up from 8'h00 with fast rate.
  - Required: after 60 ticks out goes 8'h59 -> 8'h00.
  - Stimulus: then set MODE=1.
  - Required: next tick gives 8'h59, the following tick gives 8'h58.
- Start/stop:
  - Stimulus: SS=0 for 100 cycles mid-count, then SS=1.
  - Required: out constant throughout the hold; the remaining prescaler count resumes with no lost or extra tick.
- Slow rate and speed switch:
  - Stimulus: sel=0 from reset.
  - Required: first tick on edge 10.
  - Stimulus: toggle sel to 1 with prescaler at 7.
  - Required: no tick on the toggle edge; next tick exactly 4 edges later.
- Asynchronous reset mid-count:
  - Stimulus: assert reset=0 between clock edges while out=8'h37.
  - Required: out=8'h00 immediately, without waiting for a clock edge; counting restarts from 0 after release.
- BCD digit boundaries:
  - Stimulus: count up through 8'h09, and count down through 8'h10.
  - Required: 8'h09 -> 8'h10 and 8'h10 -> 8'h09; out never shows a hex digit A-F.
